// File: rtl/pipeline_ring.sv
// Single-clock circular-buffer delay line: NCH channels of DW bits share one
// RAM and one wptr/rptr pair, with a HOLD/FILL/RUN sequencer around it.
module pipeline_ring #(
  parameter int NCH        = 12,
  parameter int DW         = 96,
  parameter int AW         = 9,
  parameter int HOLD_CYC   = 4,
  parameter bit AUTO_START = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RESTART,
  input  logic [AW-1:0]     PDEPTH,
  input  logic [NCH-1:0]    CH_EN,
  input  logic              TP_SEL,
  input  logic              TP_PULSE,
  input  logic [NCH*DW-1:0] DIN,
  output logic [NCH*DW-1:0] DOUT,
  output logic              DVALID,
  output logic [1:0]        STATE,
  output logic [AW:0]       OCC,
  output logic              DCHG
);

  localparam int W     = NCH * DW;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FILL = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t        state;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] pd_lat;
  logic [AW-1:0] pd_clamp;
  logic [AW:0]   occ;
  logic [3:0]    hcnt;
  logic          dchg;
  logic          rd_pend;
  logic          depth_mismatch;
  logic          go_hold;
  logic          we;
  logic          re;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  rd_q;
  logic [W-1:0]  rd_masked;
  logic [W-1:0]  mem [DEPTH];

  assign pd_clamp       = (PDEPTH < AW'(2)) ? AW'(2) : PDEPTH;
  assign depth_mismatch = (state == RUN) && !RESTART && (pd_clamp != pd_lat);

  // Every path into HOLD resets pointers and re-latches the depth.
  assign go_hold = ((state == IDLE) && (AUTO_START || RESTART)) ||
                   (((state == FILL) || (state == RUN)) && RESTART) ||
                   depth_mismatch;

  assign we = RST_N && !RESTART &&
              ((state == FILL) || ((state == RUN) && (pd_clamp == pd_lat)));
  assign re = RST_N && !RESTART && (state == RUN) && (pd_clamp == pd_lat);

  always_comb begin
    wr_data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (CH_EN[c]) begin
        wr_data[c*DW +: DW] = DIN[c*DW +: DW];
        if (TP_SEL) wr_data[c*DW] = TP_PULSE;
      end
    end
  end

  // Mask on the way out too, so disabling a channel blanks it immediately.
  always_comb begin
    rd_masked = '0;
    for (int c = 0; c < NCH; c++) begin
      if (CH_EN[c]) rd_masked[c*DW +: DW] = rd_q[c*DW +: DW];
    end
  end

  // Plain synchronous-read RAM without reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (we) mem[wptr] <= wr_data;
    if (re) rd_q <= mem[rptr];
  end

  // DVALID marks exactly the DOUT samples registered from a RUN read one edge
  // earlier; there is no back-pressure, the consumer must take every sample.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      wptr    <= '0;
      rptr    <= '0;
      occ     <= '0;
      hcnt    <= '0;
      pd_lat  <= AW'(2);
      dchg    <= 1'b0;
      rd_pend <= 1'b0;
      DOUT    <= '0;
      DVALID  <= 1'b0;
    end else begin
      dchg    <= 1'b0;
      rd_pend <= re;
      DVALID  <= rd_pend;
      if (rd_pend) DOUT <= rd_masked;

      case (state)
        IDLE: ;
        HOLD: begin
          if (RESTART) hcnt <= '0;
          else if (hcnt == 4'(HOLD_CYC - 1)) state <= FILL;
          else hcnt <= hcnt + 4'd1;
        end
        FILL: begin
          if (!RESTART) begin
            wptr <= wptr + AW'(1);
            occ  <= occ + (AW+1)'(1);
            if (occ + (AW+1)'(1) == {1'b0, pd_lat}) state <= RUN;
          end
        end
        RUN: begin
          if (depth_mismatch) begin
            dchg <= 1'b1;
          end else if (!RESTART) begin
            wptr <= wptr + AW'(1);
            rptr <= rptr + AW'(1);
          end
        end
      endcase

      if (go_hold) begin
        state  <= HOLD;
        hcnt   <= '0;
        wptr   <= '0;
        rptr   <= '0;
        occ    <= '0;
        pd_lat <= pd_clamp;
      end
    end
  end

  assign STATE = state;
  assign OCC   = occ;
  assign DCHG  = dchg;

endmodule

// File: tb/tb_pipeline_ring.sv
// Randomized bench for pipeline_ring: a queue-based reference model predicts
// STATE/OCC/DVALID/DCHG/DOUT after every edge; a second AUTO_START=0 copy covers IDLE.
module tb_pipeline_ring;

  localparam int NCH      = 12;
  localparam int DW       = 96;
  localparam int AW       = 9;
  localparam int HOLD_CYC = 4;
  localparam int W        = NCH * DW;

  // clock / reset and stimulus
  logic           clk = 1'b0;
  logic           rst_n;
  logic           restart;
  logic [AW-1:0]  pdepth;
  logic [NCH-1:0] ch_en;
  logic           tp_sel;
  logic           tp_pulse;
  logic [W-1:0]   din;
  int             din_mode;

  logic [W-1:0]   dout, dout1;
  logic           dvalid, dvalid1;
  logic [1:0]     state, state1;
  logic [AW:0]    occ, occ1;
  logic           dchg, dchg1;

  int total = 0;
  int bad   = 0;
  int first_dv = 0;

  // reference model: exp_q holds exactly the entries resident in the ring
  logic [W-1:0] exp_q[$];
  int           m_state, m_hcnt, m_pd;
  bit           m_pend, m_dvalid, m_dchg;
  logic [W-1:0] m_pend_data, m_dout;

  always #5 clk = ~clk;

  pipeline_ring #(.NCH(NCH), .DW(DW), .AW(AW), .HOLD_CYC(HOLD_CYC), .AUTO_START(1'b1)) u_dut (
    .CLK(clk), .RST_N(rst_n), .RESTART(restart), .PDEPTH(pdepth), .CH_EN(ch_en),
    .TP_SEL(tp_sel), .TP_PULSE(tp_pulse), .DIN(din), .DOUT(dout), .DVALID(dvalid),
    .STATE(state), .OCC(occ), .DCHG(dchg)
  );

  pipeline_ring #(.NCH(NCH), .DW(DW), .AW(AW), .HOLD_CYC(HOLD_CYC), .AUTO_START(1'b0)) u_dut_a0 (
    .CLK(clk), .RST_N(rst_n), .RESTART(restart), .PDEPTH(pdepth), .CH_EN(ch_en),
    .TP_SEL(tp_sel), .TP_PULSE(tp_pulse), .DIN(din), .DOUT(dout1), .DVALID(dvalid1),
    .STATE(state1), .OCC(occ1), .DCHG(dchg1)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] wr_word();
    logic [W-1:0] w;
    w = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_en[c]) w[c*DW +: DW] = {din[c*DW+1 +: DW-1], tp_sel ? tp_pulse : din[c*DW]};
    end
    return w;
  endfunction

  function automatic logic [W-1:0] apply_mask(input logic [W-1:0] d);
    logic [W-1:0] w;
    w = '0;
    for (int c = 0; c < NCH; c++) if (ch_en[c]) w[c*DW +: DW] = d[c*DW +: DW];
    return w;
  endfunction

  task automatic hold_enter(input int pdc);
    m_state = 1;
    m_hcnt  = 0;
    m_pd    = pdc;
    exp_q.delete();
  endtask

  task automatic model_step();
    int pdc;
    pdc = (pdepth < 2) ? 2 : int'(pdepth);
    if (!rst_n) begin
      m_state = 0; m_hcnt = 0; m_pd = 2; exp_q.delete();
      m_pend = 0; m_dout = '0; m_dvalid = 0; m_dchg = 0;
      return;
    end
    m_dvalid = m_pend;
    if (m_pend) m_dout = apply_mask(m_pend_data);
    m_pend = 0;
    m_dchg = 0;
    case (m_state)
      0: hold_enter(pdc);
      1: begin
        if (restart) m_hcnt = 0;
        else if (m_hcnt == HOLD_CYC - 1) m_state = 2;
        else m_hcnt++;
      end
      2: begin
        if (restart) hold_enter(pdc);
        else begin
          exp_q.push_back(wr_word());
          if (exp_q.size() == m_pd) m_state = 3;
        end
      end
      3: begin
        if (restart) hold_enter(pdc);
        else if (pdc != m_pd) begin
          m_dchg = 1;
          hold_enter(pdc);
        end else begin
          exp_q.push_back(wr_word());
          m_pend_data = exp_q.pop_front();
          m_pend = 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("state", DW'(state), DW'(m_state));
    check("occ", DW'(occ), DW'(exp_q.size()));
    check("dvalid", DW'(dvalid), DW'(m_dvalid));
    check("dchg", DW'(dchg), DW'(m_dchg));
    for (int c = 0; c < NCH; c++) check($sformatf("dout_ch%0d", c), dout[c*DW +: DW], m_dout[c*DW +: DW]);
  endtask

  task automatic a0_idle_check();
    check("a0_state", DW'(state1), DW'(0));
    check("a0_dvalid", DW'(dvalid1), DW'(0));
    check("a0_occ", DW'(occ1), DW'(0));
    check("a0_dchg", DW'(dchg1), DW'(0));
    for (int c = 0; c < NCH; c++) check("a0_dout", dout1[c*DW +: DW], DW'(0));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (din_mode == 1) begin
        for (int k = 0; k < W/32; k++) din[k*32 +: 32] = $urandom;
      end else if (din_mode == 2) begin
        din = '1;
      end
      tp_pulse = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; restart = 1'b0; pdepth = AW'(10); ch_en = '1;
    tp_sel = 1'b0; tp_pulse = 1'b0; din = '0; din_mode = 0;
    repeat (3) tick();
    a0_idle_check();

    // start-up with counter data: HOLD 4, FILL 10, first DVALID after edge 17
    rst_n = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      for (int c = 0; c < NCH; c++) din[c*DW +: DW] = DW'(i);
      tick();
      if (i % 10 == 0) a0_idle_check();
      if (dvalid === 1'b1 && first_dv == 0) begin
        first_dv = i;
        check("first_sample", dout[DW-1:0], DW'(6));
      end
    end
    check("first_dvalid_edge", DW'(first_dv), DW'(17));

    din_mode = 1;
    pdepth = AW'(0);   run(40);
    pdepth = AW'(511); run(2000);
    pdepth = AW'(10);  run(60);
    pdepth = AW'(20);  run(80);
    pdepth = AW'(10); restart = 1'b1; run(1); restart = 1'b0; run(60);

    // restart mid-FILL, then mid-RUN
    restart = 1'b1; run(1); restart = 1'b0; run(HOLD_CYC + 5);
    restart = 1'b1; run(1); restart = 1'b0; run(40);
    restart = 1'b1; run(1); restart = 1'b0; run(40);

    // random mix of restarts, depth changes, masks and test pulses
    for (int i = 0; i < 800; i++) begin
      restart = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) pdepth = AW'($urandom_range(0, 40));
      if ($urandom_range(0, 29) == 0) ch_en = NCH'($urandom);
      tp_sel = 1'($urandom_range(0, 1));
      run(1);
    end
    restart = 1'b0; tp_sel = 1'b0; ch_en = '1; pdepth = AW'(10);
    run(40);

    // test-pulse injection on channel 0 only, all-ones data
    ch_en = 12'h001; tp_sel = 1'b1; din_mode = 2; run(60);
    check("tp_ch0_upper", DW'(dout[DW-1:1]), {1'b0, {(DW-1){1'b1}}});
    check("tp_ch1_zero", dout[DW +: DW], DW'(0));

    // one-cycle reset mid-RUN
    ch_en = '1; tp_sel = 1'b0; din_mode = 1; run(40);
    rst_n = 1'b0; run(1);
    check("rst_state", DW'(state), DW'(0));
    check("rst_dvalid", DW'(dvalid), DW'(0));
    check("rst_occ", DW'(occ), DW'(0));
    check("rst_dout", dout[DW-1:0], DW'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run(1);
      a0_idle_check();
    end
    restart = 1'b1; run(1); restart = 1'b0;
    check("a0_restart_hold", DW'(state1), DW'(1));
    run(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ring.md
# pipeline_ring

Parametrised single-clock circular-buffer pipeline that delays NCH channels of DW-bit DAQ samples by a programmable number of cycles (PDEPTH) before readout. It is the next-generation replacement for the per-segment dual-clock FIFO pipelines. All channels share one write/read pointer pair, so they stay aligned by construction. It adds a built-in start/hold/fill sequencer, per-channel enable masking, test-pulse injection, occupancy reporting and automatic restart on depth change.

## Interface
Parameters:
- NCH, 12, number of channels
- DW, 96, bits per channel
- AW, 9, address width; ring depth is 2^AW entries
- HOLD_CYC, 4, settle cycles in HOLD before filling (range 1..15)
- AUTO_START, 1, 1 = leave IDLE automatically after reset; 0 = wait for RESTART

Ports:
- CLK  in  1  pipeline clock; all logic is on its rising edge
- RST_N  in  1  synchronous, active-low reset
- RESTART  in  1  single-cycle pulse; flushes the pipeline and re-fills it
- PDEPTH  in  AW  requested delay in cycles; clamped to 2..2^AW-1
- CH_EN  in  NCH  per-channel enable; a disabled channel stores and outputs zeros
- TP_SEL  in  1  when 1, TP_PULSE replaces bit 0 of every enabled channel's write data
- TP_PULSE  in  1  test-pulse level
- DIN  in  NCH*DW  channel c is at [c*DW +: DW]
- DOUT  out  NCH*DW  registered delayed data
- DVALID  out  1  DOUT holds valid delayed data
- STATE  out  2  IDLE=0, HOLD=1, FILL=2, RUN=3
- OCC  out  AW+1  entries currently held in the pipeline
- DCHG  out  1  one-cycle pulse when a PDEPTH change forces a restart

## Operation
- Write data per channel: CH_EN[c] ? {DIN[c][DW-1:1], TP_SEL ? TP_PULSE : DIN[c][0]} : 0.
- Storage is a synchronous-read RAM of 2^AW x (NCH*DW); inference as block RAM is required.
- The pointers wptr and rptr are AW bits wide and wrap modulo 2^AW.
- pd_lat is the clamped PDEPTH, latched on HOLD entry; it is the only depth used until the next HOLD.

State machine:
- IDLE: no writes, no reads. If AUTO_START=1, go to HOLD on the first cycle with RST_N=1. If AUTO_START=0, go to HOLD on RESTART.
- HOLD: wptr=rptr=0, OCC=0, DVALID=0, hold counter increments each cycle. Go to FILL when the count reaches HOLD_CYC-1. RESTART during HOLD clears the hold counter and HOLD continues.
- FILL: write every cycle, wptr++, OCC++. On the write that makes OCC equal to pd_lat, go to RUN.
- RUN: write at wptr and read at rptr every cycle, with rptr = wptr - pd_lat (mod 2^AW). Both pointers increment and OCC stays at pd_lat. Read and write addresses never coincide.
- From FILL or RUN, RESTART takes the block to HOLD.
- In RUN, if clamp(PDEPTH) != pd_lat and RESTART=0, pulse DCHG and go to HOLD. If RESTART=1 on the same cycle, take the RESTART path with no DCHG pulse.
- PDEPTH changes during FILL are ignored until the next HOLD.

Outputs:
- DOUT registers the RAM read data on the edge after each RUN read.
- DVALID is 1 exactly for those registered samples.
- Leaving RUN: DVALID drops on the next edge and DOUT holds its last value.
- Disabled channels output zero regardless of stored content; the mask is applied at the DOUT register.

## Timing
- Reset values: STATE=IDLE, DOUT=0, DVALID=0, OCC=0, DCHG=0, wptr=rptr=0, hold counter=0, pd_lat=2. RAM contents are not reset.
- Synchronous reset overrides every other input in any state, mid-FILL or mid-RUN included.
- Latency: a sample captured at edge n appears on DOUT with DVALID=1 after edge n+pd_lat+1.
- Start-up (AUTO_START=1), counting edges with RST_N=1:
  - edge 1: IDLE to HOLD.
  - HOLD occupies HOLD_CYC edges.
  - FILL occupies pd_lat edges.
  - the first DVALID follows one edge after the first RUN edge.
- RESTART sampled at edge e: STATE=HOLD after e, the write at e is suppressed, and DVALID=0 after e+1.
- DCHG is high for exactly the cycle after the edge where the mismatch is detected.

## Test plan
- Defaults, PDEPTH=10, incrementing counter on every channel:
  - STATE sequence IDLE, HOLD for 4 cycles, FILL for 10 cycles, RUN.
  - first DVALID carries the sample from the first FILL cycle.
  - DOUT = DIN delayed by 11 cycles continuously; OCC=10 in RUN.
- Depth clamp and wrap:
  - PDEPTH=0 gives pd_lat=2 and latency 3.
  - PDEPTH=511 gives latency 512; run 2000 cycles with no data corruption across pointer wrap.
- Depth change in RUN, PDEPTH 10 to 20:
  - DCHG pulses once, DVALID drops, HOLD then FILL of 20.
  - latency is 21 afterwards.
  - Repeat with RESTART on the same cycle: no DCHG.
- RESTART mid-FILL and mid-RUN: OCC returns to 0 and DVALID drops after 1 edge. No stale pre-restart samples appear after refill.
- CH_EN=12'h001, TP_SEL=1, TP_PULSE toggling, DIN all-ones:
  - channel 0 DOUT = {95'h7FF..F, delayed TP_PULSE}.
  - channels 1..11 DOUT = 0.
- RST_N low for one cycle mid-RUN: all outputs at reset values on the next edge. With AUTO_START=0 the block stays in IDLE until RESTART.
